reg_file_8x16: RTL
==================

Name: reg_file_8x16

Overview:
- 8-entry × 16-bit general-purpose register file for the 16-bit single-cycle CPU.
- Write side is a 1-to-8 demux/decoder: 3-bit address plus enable produce a one-hot strobe that loads exactly one register.
- Read side provides two combinational ports (rs, rt) for the datapath.
- R0 reads as zero and ignores writes.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: address width; register count is 2**ADDR_W = 8.

Ports:
- CLK  in  1  system clock; all register updates occur on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low; clears all state.
- WE  in  1  write enable for the write port.
- WA  in  ADDR_W  write address (S2..S0 order: WA[2] is MSB).
- WD  in  DATA_W  write data.
- RA0  in  ADDR_W  read address, port 0 (rs).
- RA1  in  ADDR_W  read address, port 1 (rt).
- RD0  out  DATA_W  read data, port 0.
- RD1  out  DATA_W  read data, port 1.
- WR_ONEHOT  out  8  registered one-hot copy of the last accepted write strobe (debug/observability).
- WR_CNT  out  8  count of accepted writes, wraps.

Behaviour:
- Reset (RST_N = 0, any time, independent of CLK):
  - R0..R7 = 16'h0000.
  - WR_ONEHOT = 8'h00.
  - WR_CNT = 8'h00.
  - RD0/RD1 consequently read 0.
- Decoder (combinational): strobe[k] = WE & (WA == k), for k = 0..7. At most one bit is set.
- Accepted write: WE = 1 and WA != 0.
  - On the rising CLK edge: R[WA] <= WD; WR_ONEHOT <= strobe; WR_CNT <= WR_CNT + 1 (mod 256).
- Write to R0 (WE = 1, WA = 0):
  - No register changes and WR_CNT holds.
  - WR_ONEHOT <= 8'h01, so the bench can see the decode.
- WE = 0: all registers and WR_CNT hold; WR_ONEHOT <= 8'h00.
- Read: RD0 = (RA0 == 0) ? 0 : R[RA0], and likewise RD1. Purely combinational (8:1 mux per bit).
- Latency:
  - Write becomes visible on RD* in the cycle after the edge (no bypass by default).
  - Read-during-write to the same address returns the old value.
- Both read ports may address the same register simultaneously; both return identical data.
- WR_CNT wraps from 8'hFF to 8'h00 with no flag.
- Reset asserted mid-cycle with WE = 1: reset wins, and no write occurs on the following edge while RST_N = 0.
- Reset release is synchronized externally; the block only requires that RST_N deassert away from the CLK edge.
- X or Z on WA while WE = 0 must not corrupt any register.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. If WE = 1, WA != 0 and RAx == WA, then RDx = WD in the same cycle (combinational bypass). The single-cycle CPU then sees new data in the write cycle. The R0 rule still has priority: RA = 0 gives 0.
- Undefined: no forwarding; read-during-write returns the old value as described above.

Decomposition:
- Package reg_file_pkg holds:
  - DATA_W = 16, ADDR_W = 3, NUM_REGS = 8.
  - ZERO_REG = 3'd0.
  - typedef reg_addr_t (logic [2:0]) and reg_data_t (logic [15:0]).
- One sub-module, demux_1_8: inputs EN and S[2:0], output Y[7:0] one-hot. It is the inverse of the existing mux_8_1 and is unit-tested separately.
- Read muxing is inline.

Test Plan:
1. Reset: drive RST_N = 0 with WE = 1, WA = 3, WD = 16'hBEEF across an edge; release. Required: RD0 (RA0 = 3) = 0, WR_CNT = 0, WR_ONEHOT = 0.
2. Walking decode: for WA = 1..7, write WD = 16'h1111 × WA one per cycle. Required:
   - WR_ONEHOT = 1<<WA after each edge.
   - Reading all 8 addresses returns 0, 1111, 2222, … 7777.
   - WR_CNT = 7.
3. R0 protection: WE = 1, WA = 0, WD = 16'hFFFF. Required: RD0 (RA0 = 0) = 0, WR_ONEHOT = 8'h01, WR_CNT unchanged.
4. Read-during-write: R5 = 16'h00AA; then WE = 1, WA = 5, WD = 16'h5555 with RA0 = RA1 = 5. Required:
   - Pre-edge RD0 = RD1 = 00AA; post-edge both read 5555.
   - With REG_FILE_BYPASS_EN: pre-edge reads 5555.
5. Counter wrap: 256 accepted writes to R2. Required: WR_CNT returns to 8'h00; R2 holds the last WD.
6. Async reset mid-operation: assert RST_N = 0 between edges after loading R7 = 16'h1234. Required: RD1 (RA1 = 7) drops to 0 immediately, before the next CLK edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the 8x16 register file.
//   DATA_W   - register width in bits
//   ADDR_W   - register address width
//   NUM_REGS - number of architectural registers (2**ADDR_W)
//   ZERO_REG - address of the hardwired-zero register
package reg_file_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  localparam logic [2:0] ZERO_REG = 3'd0;

  typedef logic [2:0]  reg_addr_t;
  typedef logic [15:0] reg_data_t;

endpackage

// File: rtl/reg_file_8x16_demux_1_8.sv
// demux_1_8: 1-to-8 decoder producing a one-hot write strobe.
//   en - enable; when low the output is all zeros
//   s  - select, s[2] is the MSB
//   y  - one-hot output, y[k] = en & (s == k)
// Built bitwise from equality compares so an X/Z select with en low still
// yields a clean all-zero strobe.
import reg_file_pkg::*;

module demux_1_8 (
  input  logic      en,
  input  reg_addr_t s,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < 8; k++) begin
      y[k] = en && (s == 3'(k));
    end
  end

endmodule

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8-entry x 16-bit register file, one write port, two
// combinational read ports. R0 reads as zero and has no storage.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset, clears all state
//   we/wa/wd  - write enable, address, data
//   ra0/rd0   - read port 0 (rs)
//   ra1/rd1   - read port 1 (rt)
//   wr_onehot - registered copy of the last decoded write strobe
//   wr_cnt    - count of accepted writes (WA != 0), wraps at 256
// Optional: define REG_FILE_BYPASS_EN to forward write data to a read port
// addressing the register being written in the same cycle.
import reg_file_pkg::*;

module reg_file_8x16 #(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [7:0]        wr_onehot,
  output logic [7:0]        wr_cnt
);

  logic [7:0]        strobe;
  logic              write_accepted;
  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [7:0]        wr_onehot_q;
  logic [7:0]        wr_cnt_q;

  demux_1_8 u_demux (
    .en (we),
    .s  (wa),
    .y  (strobe)
  );

  // strobe[0] is decoded (and reported) but never loads anything.
  assign write_accepted = |strobe[NUM_REGS-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      wr_onehot_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (strobe[k]) begin
          regs_q[k] <= wd;
        end
      end
      wr_onehot_q <= strobe;
      if (write_accepted) begin
        wr_cnt_q <= wr_cnt_q + 8'd1;
      end
    end
  end

  // 8:1 read muxes; address 0 falls through to the zero default.
  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (ra0 == ADDR_W'(k)) rd0 = regs_q[k];
      if (ra1 == ADDR_W'(k)) rd1 = regs_q[k];
    end
`ifdef REG_FILE_BYPASS_EN
    // wa != 0 already implies ra != 0, so the R0 rule keeps priority.
    if (we && (wa != ZERO_REG) && (ra0 == wa)) rd0 = wd;
    if (we && (wa != ZERO_REG) && (ra1 == wa)) rd1 = wd;
`endif
  end

  assign wr_onehot = wr_onehot_q;
  assign wr_cnt    = wr_cnt_q;

endmodule
